// File: rtl/alu_secuencial_pkg.sv
// Shared definitions for the sequential ALU.
// Opcode encodings (the combinational ALU set plus SLL and MUL) and the
// FSM state encodings used by alu_secuencial.
package alu_secuencial_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SRA = 4'h5,
    OP_SRL = 4'h6,
    OP_NOR = 4'h7,
    OP_SLL = 4'h8,
    OP_MUL = 4'h9
  } alu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       load a/b and clear the accumulator and step counter
//   a, b        B_DAT-bit unsigned operands (sampled only on start)
//   done        B_DAT steps have completed since the last start
//   product     2*B_DAT-bit product, valid while done=1
module alu_mul_iter #(
  parameter int B_DAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [B_DAT-1:0]   a,
  input  logic [B_DAT-1:0]   b,
  output logic               done,
  output logic [2*B_DAT-1:0] product
);

  localparam int              CW    = $clog2(B_DAT) + 1;
  localparam logic [CW-1:0]   STEPS = CW'(B_DAT);

  logic [2*B_DAT-1:0] mcand;
  logic [2*B_DAT-1:0] acc;
  logic [B_DAT-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{B_DAT{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy && (cnt != STEPS)) begin
      // One multiplier bit per cycle, LSB first.
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign done    = busy && (cnt == STEPS);
  assign product = acc;

endmodule

// File: rtl/alu_secuencial.sv
// Registered, valid/ready handshaked ALU with flags.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operation handshake (accepted only in IDLE)
//   a, b, op             operands and opcode (alu_op_e encoding)
//   out_valid/out_ready  result handshake (result held in DONE)
//   rdo                  result
//   carry, zero, overflow, negative, illegal  result flags
// Single-cycle ops finish on the accepting edge; MUL runs B_DAT shift-add
// steps in alu_mul_iter and is registered one cycle after the last step.
module alu_secuencial
  import alu_secuencial_pkg::*;
#(
  parameter int B_DAT  = 8,
  parameter int B_OP   = OP_W,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_DAT-1:0] a,
  input  logic [B_DAT-1:0] b,
  input  logic [B_OP-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [B_DAT-1:0] rdo,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic             illegal
);

  localparam int               M      = B_DAT - 1;
  localparam logic [B_DAT-1:0] SH_LIM = B_DAT[B_DAT-1:0];

  logic [1:0]           state;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*B_DAT-1:0]   mul_prod;
  logic [B_DAT-1:0]     mul_lo;

  logic [B_DAT:0]       sum;
  logic [B_DAT:0]       diff;
  logic                 big_shift;
  logic [B_DAT-1:0]     res;
  logic                 res_c;
  logic                 res_v;
  logic                 res_ill;

  assign in_ready  = (state == ST_IDLE);
  assign is_mul    = MUL_EN && (op == OP_MUL);
  assign mul_start = in_ready && in_valid && is_mul;
  assign mul_lo    = mul_prod[B_DAT-1:0];

  alu_mul_iter #(.B_DAT(B_DAT)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath, evaluated on the live inputs; only the accepting
  // edge registers it, so later input changes have no effect.
  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_ill   = 1'b0;
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    big_shift = (b >= SH_LIM);
    case (op)
      OP_ADD: begin
        res   = sum[B_DAT-1:0];
        res_c = sum[B_DAT];
        res_v = (a[M] == b[M]) && (res[M] != a[M]);
      end
      OP_SUB: begin
        res   = diff[B_DAT-1:0];
        res_c = diff[B_DAT];  // borrow: a < b unsigned
        res_v = (a[M] != b[M]) && (res[M] != a[M]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRA: res = big_shift ? {B_DAT{a[M]}} : B_DAT'($signed(a) >>> b);
      OP_SRL: res = big_shift ? '0 : (a >> b);
      OP_SLL: res = big_shift ? '0 : (a << b);
      OP_MUL: res_ill = !MUL_EN;  // enabled MUL is handled by alu_mul_iter
      default: res_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      rdo       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              state <= ST_CALC;
            end else begin
              rdo       <= res;
              carry     <= res_c;
              zero      <= (res == '0);
              overflow  <= res_v;
              negative  <= res[M];
              illegal   <= res_ill;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          if (mul_done) begin
            rdo       <= mul_lo;
            carry     <= |mul_prod[2*B_DAT-1:B_DAT];
            zero      <= (mul_lo == '0);
            overflow  <= 1'b0;
            negative  <= mul_lo[M];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed self-checking bench for alu_secuencial (B_DAT=8).
// A second instance built with MUL_EN=0 checks that MUL is flagged illegal.
module tb_alu_secuencial;
  import alu_secuencial_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic       in_ready, out_valid, carry, zero, overflow, negative, illegal;
  logic [7:0] rdo;

  logic       n_in_valid = 1'b0, n_out_ready = 1'b0;
  logic [7:0] n_a = '0, n_b = '0;
  logic [3:0] n_op = '0;
  logic       n_in_ready, n_out_valid, n_carry, n_zero, n_overflow, n_negative, n_illegal;
  logic [7:0] n_rdo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_secuencial #(.B_DAT(8), .B_OP(4), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .rdo(rdo), .carry(carry), .zero(zero), .overflow(overflow),
    .negative(negative), .illegal(illegal)
  );

  alu_secuencial #(.B_DAT(8), .B_OP(4), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .op(n_op), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .rdo(n_rdo), .carry(n_carry), .zero(n_zero), .overflow(n_overflow),
    .negative(n_negative), .illegal(n_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op while in IDLE; returns after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Result + flags of a single-cycle op, sampled one cycle after acceptance.
  task automatic expect_res(input string tag, input logic [7:0] r, input logic c,
                            input logic z, input logic v, input logic n, input logic il);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".rdo"}, rdo, r);
    check({tag, ".carry"}, carry, c);
    check({tag, ".zero"}, zero, z);
    check({tag, ".overflow"}, overflow, v);
    check({tag, ".negative"}, negative, n);
    check({tag, ".illegal"}, illegal, il);
  endtask

  task automatic single(input string tag, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] r, input logic c,
                        input logic z, input logic v, input logic n, input logic il);
    issue(o, x, y);
    expect_res(tag, r, c, z, v, n, il);
    take();
    check({tag, ".idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int cyc;

    // Reset, two cycles low.
    tick(); tick();
    check("rst.rdo", rdo, 0);
    check("rst.flags", {carry, zero, overflow, negative, illegal}, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    //     tag        op      a      b      rdo    c  z  v  n  il
    single("add_ff01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0);
    single("add_7f01", OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
    single("sub_0507", OP_SUB, 8'h05, 8'h07, 8'hFE, 1, 0, 0, 1, 0);
    single("sub_8001", OP_SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0, 0);
    single("sra_b9",   OP_SRA, 8'h90, 8'd9,  8'hFF, 0, 0, 0, 1, 0);
    single("sra_b2",   OP_SRA, 8'h90, 8'd2,  8'hE4, 0, 0, 0, 1, 0);
    single("srl_b4",   OP_SRL, 8'h90, 8'd4,  8'h09, 0, 0, 0, 0, 0);
    single("sll_b1",   OP_SLL, 8'h81, 8'd1,  8'h02, 0, 0, 0, 0, 0);
    single("sll_b8",   OP_SLL, 8'h81, 8'd8,  8'h00, 0, 1, 0, 0, 0);
    single("nor",      OP_NOR, 8'h0F, 8'hF0, 8'h00, 0, 1, 0, 0, 0);
    single("xor",      OP_XOR, 8'hA5, 8'h0F, 8'hAA, 0, 0, 0, 1, 0);
    single("undef",    4'hF,   8'h12, 8'h34, 8'h00, 0, 1, 0, 0, 1);

    // MUL 0x10*0x11 = 0x0110: out_valid exactly 9 cycles after acceptance.
    issue(OP_MUL, 8'h10, 8'h11);
    a = 8'hFF; b = 8'hFF;  // must be ignored after acceptance
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check("mul.busy_in_ready", in_ready, 0);
      tick();
      cyc++;
    end
    check("mul.latency", cyc, 9);
    expect_res("mul", 8'h10, 1, 0, 0, 0, 0);

    // Stall the result for 3 cycles with a competing op presented.
    in_valid = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.rdo", rdo, 8'h10);
      check("stall.out_valid", out_valid, 1);
      check("stall.in_ready", in_ready, 0);
    end
    take();  // in_valid still high: must not be accepted on the take edge
    check("take.out_valid", out_valid, 0);
    check("take.in_ready", in_ready, 1);
    check("take.rdo_held", rdo, 8'h10);
    tick();  // now accepted from IDLE
    in_valid = 1'b0;
    expect_res("after_take_add", 8'h02, 0, 0, 0, 0, 0);
    take();

    // Reset 4 cycles into a MUL aborts it.
    issue(OP_MUL, 8'h0F, 8'h0F);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    check("abort.in_ready", in_ready, 1);
    check("abort.out_valid", out_valid, 0);
    check("abort.rdo", rdo, 0);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) cyc++;
    end
    check("abort.no_result", cyc, 0);

    // MUL_EN=0 build: MUL is a single-cycle illegal op.
    n_in_valid = 1'b1; n_op = OP_MUL; n_a = 8'h03; n_b = 8'h05;
    tick();
    n_in_valid = 1'b0;
    check("nomul.out_valid", n_out_valid, 1);
    check("nomul.illegal", n_illegal, 1);
    check("nomul.rdo", n_rdo, 0);
    check("nomul.zero", n_zero, 1);
    n_out_ready = 1'b1;
    tick();
    n_out_ready = 1'b0;
    check("nomul.idle", {n_out_valid, n_in_ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
